// File: rtl/axis_sync_fifo_pkt_if.sv
// AXI-Stream beat channel (tvalid/tready/tdata/tlast) shared by the FIFO's
// input and output sides.
interface axis_sync_fifo_pkt_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo_pkt.sv
// Single-clock AXI-Stream packet FIFO: RAM plus one output register, with
// fill level, almost flags, high-water mark and synchronous flush.
module axis_sync_fifo_pkt #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                   axis_clk,
  input  logic                   rst,
  input  logic                   flush,
  axis_sync_fifo_pkt_if.slave    s_axis,
  axis_sync_fifo_pkt_if.master   m_axis,
  output logic [ADDR_WIDTH:0]    fill_count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDR_WIDTH:0]    high_water
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_V    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_V    = (ADDR_WIDTH+1)'(AE_THRESH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t                mem [DEPTH];
  beat_t                out_q;
  logic                 out_vld;
  logic                 ready_q;
  logic [ADDR_WIDTH:0]  wr_ptr, rd_ptr, fill_next;
  logic                 wr_en, rd_en, mem_empty, pop;

  assign s_axis.tready = ready_q && !flush;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_q.data;
  assign m_axis.tlast  = out_q.last;

  assign wr_en     = s_axis.tvalid && s_axis.tready;
  assign rd_en     = out_vld && m_axis.tready;
  // Wrap bit in the pointers lets equal pointers mean empty, never full.
  assign mem_empty = (wr_ptr == rd_ptr);
  // Refill the output register whenever it is empty or being drained.
  assign pop       = !mem_empty && (!out_vld || m_axis.tready);
  assign fill_next = fill_count + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);

  always_ff @(posedge axis_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= '{last: s_axis.tlast, data: s_axis.tdata};
  end

  always_ff @(posedge axis_clk) begin
    if (!rst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_vld      <= 1'b0;
      out_q        <= '0;
      fill_count   <= '0;
      high_water   <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      // Reset holds the input off for a cycle; flush reopens it at once.
      ready_q      <= rst;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_q   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        out_vld <= 1'b1;
      end else if (rd_en) begin
        out_vld <= 1'b0;
      end
      fill_count   <= fill_next;
      almost_full  <= (fill_next >= AF_V);
      almost_empty <= (fill_next <= AE_V);
      high_water   <= (fill_next > high_water) ? fill_next : high_water;
      ready_q      <= (fill_next < DEPTH_V);
    end
  end
endmodule
